// File: rtl/imem_loader_pkg.sv
// Shared definitions for the PMIPSL0 instruction-memory loader:
// memory geometry, loader state encoding and a byte-join helper.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int IMEM_DEPTH  = 128;

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_RUN     = 3'd4
    } ld_state_e;

    // Streams carry the high byte first.
    function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_array.sv
// DEPTH x 16 instruction storage: synchronous write, asynchronous read.
// Contents are never cleared; the loader's word count gates what is visible.
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream, holds the
// processor in reset until loading finishes, then serves fetches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       imemaddr,
    output logic [15:0]       imemrdata,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;
    logic [7:0]        r_byte;
    logic [15:0]       r_remain;
    logic [ADDR_W:0]   r_word_count;
    logic              r_load_ready;
    logic              r_cpu_reset;
    logic              r_load_done;
    logic              r_load_error;

    logic              w_accept;
    logic              w_we;
    logic [15:0]       w_word;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [15:0]       w_rdata;
    logic              w_rd_ok;
    logic              w_unused_addr_lsb;

    assign w_word            = join_bytes(r_byte, load_data);
    assign w_rd_idx          = imemaddr[ADDR_W:1];
    assign w_unused_addr_lsb = imemaddr[0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_LEN_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and write-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_accept    = load_valid && r_load_ready;
        case (r_state)
            ST_LEN_HI: begin
                if (w_accept) w_state_nxt = ST_LEN_LO;
                else          w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_word == 16'h0000) w_state_nxt = ST_RUN;
                    else                    w_state_nxt = ST_DATA_HI;
                end else begin
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_DATA_HI: begin
                if (w_accept) w_state_nxt = ST_DATA_LO;
                else          w_state_nxt = ST_DATA_HI;
            end
            ST_DATA_LO: begin
                if (w_accept) begin
                    w_we = (r_word_count < L_DEPTH);
                    if (r_remain == 16'd1) w_state_nxt = ST_RUN;
                    else                   w_state_nxt = ST_DATA_HI;
                end else begin
                    w_state_nxt = ST_DATA_LO;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_LEN_HI;
        endcase
    end

    // Datapath: byte latch, counters and registered handshake/status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte       <= 8'h00;
            r_remain     <= 16'h0000;
            r_word_count <= '0;
            r_load_ready <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_load_ready <= (w_state_nxt != ST_RUN);
            r_cpu_reset  <= (w_state_nxt != ST_RUN);
            r_load_done  <= (w_state_nxt == ST_RUN);
            if (w_accept) begin
                case (r_state)
                    ST_LEN_HI:  r_byte <= load_data;
                    ST_LEN_LO: begin
                        r_remain     <= w_word;
                        r_word_count <= '0;
                    end
                    ST_DATA_HI: r_byte <= load_data;
                    ST_DATA_LO: begin
                        // word_count doubles as the write index and saturates at DEPTH
                        if (w_we) r_word_count <= r_word_count + {{ADDR_W{1'b0}}, 1'b1};
                        else      r_load_error <= 1'b1;
                        r_remain <= r_remain - 16'd1;
                    end
                    default: r_byte <= r_byte;
                endcase
            end
        end
    end

    imem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock  (clock),
        .we     (w_we),
        .waddr  (r_word_count[ADDR_W-1:0]),
        .wdata  (w_word),
        .raddr  (w_rd_idx),
        .rdata  (w_rdata)
    );

    // Fetch gating: only loaded, in-range words are visible, and only once running
    always_comb begin
        w_rd_ok = (r_state == ST_RUN) &&
                  (imemaddr[15:ADDR_W+1] == {(15-ADDR_W){1'b0}}) &&
                  ({1'b0, w_rd_idx} < r_word_count);
        if (w_rd_ok) imemrdata = w_rdata;
        else         imemrdata = 16'h0000;
    end

    assign load_ready = r_load_ready;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_imem_loader;

    localparam int K_RDATA = 0, K_WC = 1, K_DONE = 2, K_CPURST = 3, K_ERR = 4, K_READY = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imemaddr = 16'h0000;
    logic [15:0] imemrdata;
    logic [7:0]  load_data = 8'h00;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [7:0]  word_count;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    logic prev_done = 1'b0;

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .imemaddr   (imemaddr),
        .imemrdata  (imemrdata),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_RDATA:  return imemrdata;
            K_WC:     return {8'h00, word_count};
            K_DONE:   return {15'd0, load_done};
            K_CPURST: return {15'd0, cpu_reset};
            K_ERR:    return {15'd0, load_error};
            default:  return {15'd0, load_ready};
        endcase
    endfunction

    // Monitor: scoreboard pops, accept counting and load_done edge check
    always @(negedge clock) begin
        exp_t e;
        int   exp_acc;
        logic [15:0] got;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = observe(e.kind);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        n_checks++;
        if (cpu_reset !== ~load_done) begin
            n_fail++;
            $display("FAIL cpu_reset_vs_done: got cpu_reset=%b expected %b", cpu_reset, ~load_done);
        end
        if (load_done && !prev_done) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got rise after %0d accepts expected no rise", acc_cnt);
            end else begin
                exp_acc = done_q.pop_front();
                if (acc_cnt != exp_acc) begin
                    n_fail++;
                    $display("FAIL done_latency: got %0d accepts expected %0d", acc_cnt, exp_acc);
                end
            end
        end
        prev_done = load_done;
        if (reset) acc_cnt = 0;
        else if (load_valid && load_ready) acc_cnt++;
    end

    task automatic chk(input string name, input int kind, input logic [15:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic flush();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [15:0] addr, input logic [15:0] val);
        imemaddr = addr;
        chk(name, K_RDATA, val);
        flush();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Presents one byte until it is accepted; optional idle cycle afterwards
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited = 0;
        load_data  = b;
        load_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (load_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_timeout: got no accept expected accept of %h", b);
                break;
            end
        end
        @(posedge clock);
        #1;
        if (gap) begin
            load_valid = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input bit gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
        load_valid = 1'b0;
    endtask

    task automatic check_prog3(input string tag);
        chk({tag, "_wc"}, K_WC, 16'd3);
        chk({tag, "_cpurst"}, K_CPURST, 16'd0);
        chk({tag, "_done"}, K_DONE, 16'd1);
        chk({tag, "_err"}, K_ERR, 16'd0);
        flush();
        read_chk({tag, "_rd0"}, 16'h0000, 16'h6083);
        read_chk({tag, "_rd2"}, 16'h0002, 16'h6C84);
        read_chk({tag, "_rd4"}, 16'h0004, 16'h0C43);
        read_chk({tag, "_rd6"}, 16'h0006, 16'h0000);
    endtask

    initial begin
        logic [7:0] s[$];
        do_reset();
        // reset state, first cycle after reset: not ready
        imemaddr = 16'h0000;
        chk("rst_ready", K_READY, 16'd0);
        chk("rst_wc", K_WC, 16'd0);
        chk("rst_cpurst", K_CPURST, 16'd1);
        chk("rst_done", K_DONE, 16'd0);
        chk("rst_err", K_ERR, 16'd0);
        chk("rst_rdata", K_RDATA, 16'h0000);
        flush();

        // 3-word program, valid every cycle
        s = '{8'h00, 8'h03, 8'h60, 8'h83, 8'h6C, 8'h84, 8'h0C, 8'h43};
        done_q.push_back(8);
        send_stream(s, 1'b0);
        check_prog3("t1");
        read_chk("t1_rd_oor", 16'h0100, 16'h0000);
        read_chk("t1_rd_odd", 16'h0001, 16'h6083);
        load_valid = 1'b1;
        load_data  = 8'hAA;
        chk("t1_ready_run", K_READY, 16'd0);
        flush();
        chk("t1_ready_run2", K_READY, 16'd0);
        chk("t1_wc_hold", K_WC, 16'd3);
        flush();
        load_valid = 1'b0;

        // same program with valid toggling
        do_reset();
        done_q.push_back(8);
        send_stream(s, 1'b1);
        check_prog3("t2");

        // empty program
        do_reset();
        s = '{8'h00, 8'h00};
        done_q.push_back(2);
        send_stream(s, 1'b0);
        chk("t3_wc", K_WC, 16'd0);
        chk("t3_err", K_ERR, 16'd0);
        chk("t3_done", K_DONE, 16'd1);
        flush();
        read_chk("t3_rd0", 16'h0000, 16'h0000);
        read_chk("t3_rd2", 16'h0002, 16'h0000);
        read_chk("t3_rd254", 16'h00FE, 16'h0000);

        // overflow: 129 words, word k = k
        do_reset();
        s = '{8'h00, 8'h81};
        for (int k = 0; k < 129; k++) begin
            s.push_back(8'h00);
            s.push_back(8'(k));
        end
        done_q.push_back(260);
        send_stream(s, 1'b0);
        chk("t4_err", K_ERR, 16'd1);
        chk("t4_wc", K_WC, 16'd128);
        flush();
        read_chk("t4_rd254", 16'h00FE, 16'h007F);
        read_chk("t4_rd0", 16'h0000, 16'h0000);
        read_chk("t4_rd2", 16'h0002, 16'h0001);
        read_chk("t4_rd256", 16'h0100, 16'h0000);

        // reset in the middle of a 3-word load, then a fresh 1-word load
        do_reset();
        s = '{8'h00, 8'h03, 8'h60, 8'h83, 8'h6C};
        send_stream(s, 1'b0);
        chk("t5_mid_wc", K_WC, 16'd1);
        chk("t5_mid_cpurst", K_CPURST, 16'd1);
        flush();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_rst_wc", K_WC, 16'd0);
        chk("t5_rst_cpurst", K_CPURST, 16'd1);
        chk("t5_rst_err", K_ERR, 16'd0);
        flush();
        reset = 1'b0;
        s = '{8'h00, 8'h01, 8'h12, 8'h34};
        done_q.push_back(4);
        send_stream(s, 1'b0);
        chk("t5_wc", K_WC, 16'd1);
        flush();
        read_chk("t5_rd0", 16'h0000, 16'h1234);
        read_chk("t5_rd2", 16'h0002, 16'h0000);

        repeat (2) @(posedge clock);
        while (done_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_missing: got no load_done rise expected rise after %0d accepts", done_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
